// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
package spi_pkg;

    localparam int unsigned SPI_SYNC_STAGES = 2;
    localparam int unsigned AVS_ADDR_W      = 2;
    localparam int unsigned AVS_DATA_W      = 32;

    localparam logic [AVS_ADDR_W-1:0] RXDATA_ADDR  = 2'd0;
    localparam logic [AVS_ADDR_W-1:0] TXDATA_ADDR  = 2'd1;
    localparam logic [AVS_ADDR_W-1:0] STATUS_ADDR  = 2'd2;
    localparam logic [AVS_ADDR_W-1:0] CONTROL_ADDR = 2'd3;

    localparam int unsigned ST_RX_VALID    = 0;
    localparam int unsigned ST_TX_VALID    = 1;
    localparam int unsigned ST_BUSY        = 2;
    localparam int unsigned ST_RX_OVERRUN  = 3;
    localparam int unsigned ST_TX_UNDERRUN = 4;

    localparam int unsigned CTRL_IRQ_EN = 0;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer bringing asynchronous pins into the clk domain.
module spi_sync
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = SPI_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_stage;

    // Shift the pin values through the synchronizer chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder with an Avalon-MM register file; oversamples the SPI pins in clk.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss_n,
    output logic                  miso,
    input  logic [AVS_ADDR_W-1:0] avs_address,
    input  logic                  avs_read,
    output logic [AVS_DATA_W-1:0] avs_readdata,
    input  logic                  avs_write,
    input  logic [AVS_DATA_W-1:0] avs_writedata,
    output logic                  irq
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [2:0] w_pins_s;
    logic       w_sclk_s, w_mosi_s, w_ss_n_s;
    logic       r_sclk_d, r_ss_n_d;
    logic       w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_sample, w_shift;
    logic       w_ss_fall, w_ss_rise;
    logic       w_wr_tx, w_wr_status, w_wr_ctrl, w_rd_rx;
    logic       w_unused;

    spi_state_t            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
    logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic                  r_miso, w_miso_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic [DATA_WIDTH-1:0] r_tx_buf, w_tx_buf_nxt;
    logic                  r_tx_valid, w_tx_valid_nxt;
    logic                  r_rx_overrun, w_rx_overrun_nxt;
    logic                  r_tx_underrun, w_tx_underrun_nxt;
    logic                  r_irq_en, w_irq_en_nxt;
    logic                  r_irq, w_irq_nxt;
    logic [AVS_DATA_W-1:0] r_readdata;
    logic [AVS_DATA_W-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_load_word, w_rx_word;
    logic                  w_load;

    spi_sync #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({sclk, mosi, ss_n}),
        .o_q   (w_pins_s)
    );

    assign w_sclk_s = w_pins_s[2];
    assign w_mosi_s = w_pins_s[1];
    assign w_ss_n_s = w_pins_s[0];

    // Previous synchronised sclk / ss_n for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_d <= 1'b0;
            r_ss_n_d <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_n_d <= w_ss_n_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = CPHA ? w_trail : w_lead;
    assign w_shift     = CPHA ? w_lead : w_trail;
    assign w_ss_fall   = ~w_ss_n_s & r_ss_n_d;
    assign w_ss_rise   = w_ss_n_s & ~r_ss_n_d;

    assign w_wr_tx     = avs_write && (avs_address == TXDATA_ADDR);
    assign w_wr_status = avs_write && (avs_address == STATUS_ADDR);
    assign w_wr_ctrl   = avs_write && (avs_address == CONTROL_ADDR);
    assign w_rd_rx     = avs_read && (avs_address == RXDATA_ADDR);

    // Only the low data bits and a few control bits of writedata are used.
    assign w_unused = &{1'b0, avs_writedata};

    assign w_load_word = r_tx_valid ? r_tx_buf : '0;
    assign w_rx_word   = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};

    // Next-state logic: register-side clears first, then FSM sets, then TX write.
    always_comb begin
        w_state_nxt       = r_state;
        w_tx_shift_nxt    = r_tx_shift;
        w_rx_shift_nxt    = r_rx_shift;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_miso_nxt        = r_miso;
        w_rx_data_nxt     = r_rx_data;
        w_rx_valid_nxt    = r_rx_valid;
        w_tx_buf_nxt      = r_tx_buf;
        w_tx_valid_nxt    = r_tx_valid;
        w_rx_overrun_nxt  = r_rx_overrun;
        w_tx_underrun_nxt = r_tx_underrun;
        w_irq_en_nxt      = r_irq_en;
        w_load            = 1'b0;

        if (w_rd_rx) begin
            w_rx_valid_nxt = 1'b0;
        end
        if (w_wr_status) begin
            if (avs_writedata[ST_RX_OVERRUN]) w_rx_overrun_nxt = 1'b0;
            if (avs_writedata[ST_TX_UNDERRUN]) w_tx_underrun_nxt = 1'b0;
        end
        if (w_wr_ctrl) begin
            w_irq_en_nxt = avs_writedata[CTRL_IRQ_EN];
        end

        case (r_state)
            SPI_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt   = SPI_ACTIVE;
                    w_bit_cnt_nxt = '0;
                    w_load        = 1'b1;
                    if (!CPHA) begin
                        // MSB goes out at select; the first shift edge presents the next bit.
                        w_miso_nxt     = w_load_word[DATA_WIDTH-1];
                        w_tx_shift_nxt = w_load_word << 1;
                    end else begin
                        w_tx_shift_nxt = w_load_word;
                    end
                end
            end
            SPI_ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_nxt = SPI_IDLE;
                    w_miso_nxt  = 1'b0;
                end else if (w_sample) begin
                    w_rx_shift_nxt = w_rx_word;
                    if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        w_rx_data_nxt  = w_rx_word;
                        w_rx_valid_nxt = 1'b1;
                        if (r_rx_valid && !w_rd_rx) w_rx_overrun_nxt = 1'b1;
                        w_bit_cnt_nxt  = '0;
                        w_load         = 1'b1;
                        // Unshifted: the next shift edge presents this word's MSB.
                        w_tx_shift_nxt = w_load_word;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end else if (w_shift) begin
                    w_miso_nxt     = r_tx_shift[DATA_WIDTH-1];
                    w_tx_shift_nxt = r_tx_shift << 1;
                end
            end
        endcase

        if (w_load) begin
            if (r_tx_valid) w_tx_valid_nxt = 1'b0;
            else            w_tx_underrun_nxt = 1'b1;
        end

        if (w_wr_tx) begin
            w_tx_buf_nxt   = avs_writedata[DATA_WIDTH-1:0];
            w_tx_valid_nxt = 1'b1;
        end

        w_irq_nxt = w_irq_en_nxt & w_rx_valid_nxt;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= SPI_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_miso        <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_buf      <= '0;
            r_tx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_irq_en      <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_tx_shift    <= w_tx_shift_nxt;
            r_rx_shift    <= w_rx_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_miso        <= w_miso_nxt;
            r_rx_data     <= w_rx_data_nxt;
            r_rx_valid    <= w_rx_valid_nxt;
            r_tx_buf      <= w_tx_buf_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_rx_overrun  <= w_rx_overrun_nxt;
            r_tx_underrun <= w_tx_underrun_nxt;
            r_irq_en      <= w_irq_en_nxt;
            r_irq         <= w_irq_nxt;
        end
    end

    // STATUS word assembly.
    always_comb begin
        w_status                 = '0;
        w_status[ST_RX_VALID]    = r_rx_valid;
        w_status[ST_TX_VALID]    = r_tx_valid;
        w_status[ST_BUSY]        = (r_state == SPI_ACTIVE);
        w_status[ST_RX_OVERRUN]  = r_rx_overrun;
        w_status[ST_TX_UNDERRUN] = r_tx_underrun;
    end

    // Registered Avalon read data, one cycle after the read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                RXDATA_ADDR:  r_readdata <= AVS_DATA_W'(r_rx_data);
                STATUS_ADDR:  r_readdata <= w_status;
                CONTROL_ADDR: r_readdata <= AVS_DATA_W'(r_irq_en);
                default:      r_readdata <= '0;
            endcase
        end
    end

    assign miso         = r_miso;
    assign irq          = r_irq;
    assign avs_readdata = r_readdata;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: one spi_slave per CPOL/CPHA mode, index = {CPOL, CPHA}.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sclk_v, mosi_v, ss_n_v, avs_read_v, avs_write_v;
    logic [1:0]  avs_address;
    logic [31:0] avs_writedata;
    wire  [3:0]  miso_v, irq_v;
    wire  [31:0] readdata_v [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.DATA_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .sclk          (sclk_v[g]),
            .mosi          (mosi_v[g]),
            .ss_n          (ss_n_v[g]),
            .miso          (miso_v[g]),
            .avs_address   (avs_address),
            .avs_read      (avs_read_v[g]),
            .avs_readdata  (readdata_v[g]),
            .avs_write     (avs_write_v[g]),
            .avs_writedata (avs_writedata),
            .irq           (irq_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic avs_wr(input int m, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address    = a;
        avs_writedata  = d;
        avs_write_v[m] = 1'b1;
        @(negedge clk);
        avs_write_v[m] = 1'b0;
    endtask

    task automatic avs_rd(input int m, input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_read_v[m] = 1'b1;
        @(negedge clk);
        avs_read_v[m] = 1'b0;
        d = readdata_v[m];
    endtask

    task automatic spi_select(input int m);
        @(negedge clk);
        ss_n_v[m] = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic spi_deselect(input int m);
        clk_wait(HALF);
        ss_n_v[m] = 1'b1;
        clk_wait(8);
    endtask

    // Master side: send nbits of mo MSB first, capture miso into mi.
    task automatic spi_bits(input int m, input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi);
        logic cpol, cpha;
        int   b;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        mi   = '0;
        for (int i = 0; i < nbits; i++) begin
            b = 7 - i;
            if (!cpha) begin
                mosi_v[m] = mo[b];
                clk_wait(HALF);
                mi[b]     = miso_v[m];
                sclk_v[m] = ~cpol;
                clk_wait(HALF);
                sclk_v[m] = cpol;
            end else begin
                sclk_v[m] = ~cpol;
                mosi_v[m] = mo[b];
                clk_wait(HALF);
                mi[b]     = miso_v[m];
                sclk_v[m] = cpol;
                clk_wait(HALF);
            end
        end
    endtask

    task automatic spi_xfer(input int m, input logic [7:0] mo, output logic [7:0] mi);
        spi_select(m);
        spi_bits(m, mo, 8, mi);
        spi_deselect(m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  mi;
        logic [31:0] d;
        logic [7:0]  words [3];
        logic [7:0]  exp_mi [3];

        reset         = 1'b1;
        ss_n_v        = 4'hF;
        sclk_v        = 4'b1100;
        mosi_v        = 4'h0;
        avs_read_v    = 4'h0;
        avs_write_v   = 4'h0;
        avs_address   = '0;
        avs_writedata = '0;
        clk_wait(3);
        reset = 1'b0;
        clk_wait(2);

        // Reset values.
        check("reset_miso", 32'(miso_v), 32'h0);
        check("reset_irq", 32'(irq_v), 32'h0);
        for (int m = 0; m < 4; m++) check($sformatf("reset_readdata%0d", m), readdata_v[m], 32'h0);
        avs_rd(0, STATUS_ADDR, d);
        check("reset_status", d, 32'h0);

        // Single-word loopback; the follow-on word is preloaded mid-transfer so
        // the completion reload does not underrun.
        avs_wr(0, CONTROL_ADDR, 32'h1);
        avs_wr(0, TXDATA_ADDR, 32'hA5);
        avs_rd(0, STATUS_ADDR, d);
        check("lb_status_txv", d, 32'h02);
        check("lb_irq_before", 32'(irq_v[0]), 32'h0);
        fork
            spi_xfer(0, 8'h3C, mi);
            begin
                clk_wait(20);
                avs_wr(0, TXDATA_ADDR, 32'h00);
            end
        join
        check("lb_master_rx", 32'(mi), 32'hA5);
        check("lb_irq_set", 32'(irq_v[0]), 32'h1);
        avs_rd(0, STATUS_ADDR, d);
        check("lb_status_rxv", d, 32'h01);
        avs_rd(0, RXDATA_ADDR, d);
        check("lb_rxdata", d, 32'h3C);
        avs_rd(0, STATUS_ADDR, d);
        check("lb_status_clr", d, 32'h00);
        check("lb_irq_clr", 32'(irq_v[0]), 32'h0);

        // All four CPOL/CPHA modes.
        for (int m = 0; m < 4; m++) begin
            avs_wr(m, TXDATA_ADDR, 32'h81);
            spi_xfer(m, 8'h7E, mi);
            check($sformatf("mode%0d_master_rx", m), 32'(mi), 32'h81);
            avs_rd(m, RXDATA_ADDR, d);
            check($sformatf("mode%0d_rxdata", m), d, 32'h7E);
        end

        // Back-to-back words with overrun and underrun.
        avs_wr(0, STATUS_ADDR, 32'h18);
        avs_wr(0, TXDATA_ADDR, 32'hF0);
        words  = '{8'h11, 8'h22, 8'h33};
        exp_mi = '{8'hF0, 8'h00, 8'h00};
        spi_select(0);
        for (int i = 0; i < 3; i++) begin
            spi_bits(0, words[i], 8, mi);
            check($sformatf("b2b_master_rx%0d", i), 32'(mi), 32'(exp_mi[i]));
        end
        spi_deselect(0);
        avs_rd(0, STATUS_ADDR, d);
        check("b2b_status", d, 32'h19);
        avs_rd(0, RXDATA_ADDR, d);
        check("b2b_rxdata", d, 32'h33);
        avs_wr(0, STATUS_ADDR, 32'h18);
        avs_rd(0, STATUS_ADDR, d);
        check("b2b_w1c", d, 32'h00);

        // Abort after 5 bits, then a clean transfer.
        avs_wr(0, TXDATA_ADDR, 32'h00);
        spi_select(0);
        avs_rd(0, STATUS_ADDR, d);
        check("abort_busy", d, 32'h04);
        spi_bits(0, 8'hFF, 5, mi);
        spi_deselect(0);
        avs_rd(0, STATUS_ADDR, d);
        check("abort_status", d, 32'h00);
        avs_wr(0, TXDATA_ADDR, 32'hC3);
        spi_xfer(0, 8'h5A, mi);
        check("abort_next_master_rx", 32'(mi), 32'hC3);
        avs_rd(0, RXDATA_ADDR, d);
        check("abort_next_rxdata", d, 32'h5A);

        // RXDATA read landing on the completion cycle of the next word.
        avs_wr(0, STATUS_ADDR, 32'h18);
        spi_xfer(0, 8'h96, mi);
        fork
            spi_xfer(0, 8'h69, mi);
            begin
                repeat (8) @(posedge sclk_v[0]);
                clk_wait(1);
                avs_rd(0, RXDATA_ADDR, d);
            end
        join
        check("simul_old_word", d, 32'h96);
        avs_rd(0, STATUS_ADDR, d);
        check("simul_rxv_no_ovr", d & 32'h09, 32'h01);

        // Asynchronous reset in the middle of a word.
        avs_wr(0, TXDATA_ADDR, 32'hFF);
        spi_select(0);
        spi_bits(0, 8'h00, 4, mi);
        check("rst_pre_miso", 32'(miso_v[0]), 32'h1);
        check("rst_pre_irq", 32'(irq_v[0]), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_miso", 32'(miso_v[0]), 32'h0);
        check("rst_irq", 32'(irq_v[0]), 32'h0);
        check("rst_readdata", readdata_v[0], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ss_n_v[0] = 1'b1;
        clk_wait(8);
        avs_rd(0, STATUS_ADDR, d);
        check("rst_status", d, 32'h00);
        avs_rd(0, CONTROL_ADDR, d);
        check("rst_control", d, 32'h00);
        avs_wr(0, TXDATA_ADDR, 32'h3C);
        spi_xfer(0, 8'hC3, mi);
        check("rst_after_master_rx", 32'(mi), 32'h3C);
        avs_rd(0, RXDATA_ADDR, d);
        check("rst_after_rxdata", d, 32'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
